dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Multi-cycle access controller between the pipeline MEM stage and the single-cycle 16-bit data memory. It accepts one load or store from the pipeline and holds the pipeline with `stall` for a programmable number of wait cycles. It then issues exactly one memory access and returns load data with a one-cycle valid pulse. It models the fixed-latency memory behaviour required by the later project phases without modifying the memory array itself.

## Interface
Parameters:
- DWIDTH, 16, data width
- AWIDTH, 16, byte-address width
- LATENCY, 4, wait cycles before the memory access; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  pipeline requests an access; held stable while `stall`=1
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  AWIDTH  byte address
- req_wdata  in  DWIDTH  store data
- stall  out  1  freeze pipeline (combinational)
- rdata  out  DWIDTH  load result, registered
- rdata_valid  out  1  one-cycle pulse, load result valid
- err  out  1  one-cycle pulse, misaligned request (see Configuration)
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  AWIDTH  memory byte address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory combinational read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if req_valid=1, capture req_wr/req_addr/req_wdata, load cnt=LATENCY-1, go BUSY; else stay.
- BUSY: decrement cnt each cycle; when cnt==0, drive mem_en=1, mem_wr=captured wr, mem_addr/mem_wdata from capture, then go RESP.
  - Load: latch mem_rdata into rdata at that edge.
  - Store: memory writes at that edge.
- RESP: rdata_valid=1 for a load (0 for a store), stall=0, go IDLE. A req_valid present in RESP is the already-serviced request and is ignored.
- stall = (IDLE & req_valid) | BUSY.
- mem_en/mem_wr are asserted only in the final BUSY cycle; 0 otherwise. mem_addr/mem_wdata are held from the capture registers.
- cnt is 4 bits wide and never wraps: it is loaded only in IDLE.
- rdata holds its last load value until the next load completes.

## Timing
- Cycle 0 (IDLE, req_valid): stall=1, request captured.
- Cycles 1..LATENCY (BUSY): stall=1; memory access occurs in cycle LATENCY.
- Cycle LATENCY+1 (RESP): stall=0, rdata_valid pulses for a load.
- Total stall: LATENCY+1 cycles per access. Back-to-back requests are accepted no earlier than the cycle after RESP.
- Reset values: state IDLE, cnt 0, rdata 0, rdata_valid 0, err 0, mem_en 0, mem_wr 0, mem_addr 0, mem_wdata 0, stall 0 (with req_valid=0).
- rst during BUSY: abort to IDLE. No memory write is issued, including when rst coincides with the final BUSY cycle.

## Configuration
- `DMEM_ALIGN_CHK_EN` defined: a request with req_addr[0]=1 is accepted in IDLE but skips BUSY and goes to RESP with err=1. No memory access occurs, rdata_valid=0, and stall=1 only in cycle 0.
- Not defined: err is tied 0, and mem_addr[0] is forced to 0 (the low bit is silently ignored).

## Structure
- Package dmem_ctrl_pkg: state enum (IDLE, BUSY, RESP), default LATENCY constant, cnt width constant (4).
- One natural sub-module: wait_counter, a loadable down-counter with a `zero` flag, instantiated once.

## Test plan
- Load with LATENCY=4: mem word at 0x0010 = 0xBEEF, req load addr 0x0010 -> stall high 5 cycles; mem_en=1, mem_wr=0 only in cycle 4; cycle 5 rdata=0xBEEF, rdata_valid=1.
- Store 0x1234 to 0x0020, LATENCY=4 -> mem_en=mem_wr=1 only in cycle 4. A following load of 0x0020 returns 0x1234.
- Back-to-back load, store, load with req_valid held continuously -> each access is serviced exactly once, the 1-cycle IDLE gap is present, and no duplicate write occurs.
- rst asserted in cycle 4 of a store -> no write occurs (memory word is unchanged), and all outputs are 0 in the next cycle.
- LATENCY=1 -> stall high 2 cycles, response in cycle 2.
- Misaligned load of 0x0011 with DMEM_ALIGN_CHK_EN defined -> err=1 in cycle 1, mem_en never asserted. Without the macro -> mem_addr=0x0010 and normal completion.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared types and constants for the data-memory access controller.
//   state_t      : controller FSM states (IDLE, BUSY, RESP)
//   DEF_LATENCY  : default number of wait cycles before the memory access
//   CNT_W        : width of the wait counter (supports LATENCY 1..15)
//   lat_to_cnt() : converts a latency in cycles to the counter preload value
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_LATENCY = 4;
   localparam int CNT_W       = 4;

   // The counter reaches zero in the last BUSY cycle, so it starts one
   // below the latency.
   function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/dmem_ctrl_wait_counter.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_wait_counter
// Loadable down-counter with a zero flag. Saturates at zero (never wraps).
// Ports:
//   clk, rst     : clock, synchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (has priority over decrement)
//   i_load_val   : preload value
//   i_dec        : decrement by one when nonzero
//   o_zero       : count equals zero
// -----------------------------------------------------------------------------
module dmem_ctrl_wait_counter
   import dmem_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Multi-cycle access controller between the pipeline MEM stage and a
// single-cycle data memory. Accepts one load/store, stalls the pipeline for
// LATENCY wait cycles, issues exactly one memory access in the last wait
// cycle and returns load data with a one-cycle valid pulse.
//
// Configuration macro: DMEM_ALIGN_CHK_EN
//   defined   : odd byte addresses are rejected with a one-cycle err pulse,
//               no memory access is made.
//   undefined : err is tied 0 and mem_addr[0] is forced to 0.
//
// Parameters: DWIDTH (data width), AWIDTH (byte-address width),
//             LATENCY (wait cycles, legal 1..15)
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : pipeline request, held stable while stall=1
//   req_wr          : 1 = store, 0 = load
//   req_addr        : byte address
//   req_wdata       : store data
//   stall           : combinational pipeline freeze
//   rdata           : registered load result
//   rdata_valid     : one-cycle pulse, load result valid
//   err             : one-cycle pulse, misaligned request
//   mem_en, mem_wr  : memory enable / write, only in the final BUSY cycle
//   mem_addr        : memory byte address (held from capture)
//   mem_wdata       : memory write data (held from capture)
//   mem_rdata       : combinational memory read data
// -----------------------------------------------------------------------------
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int DWIDTH  = 16,
   parameter int AWIDTH  = 16,
   parameter int LATENCY = DEF_LATENCY
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              stall,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdata_valid,
   output logic              err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LP_CNT_INIT = lat_to_cnt(LATENCY);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_wr;
   logic [AWIDTH-1:0] r_addr;
   logic [DWIDTH-1:0] r_wdata;
   logic [DWIDTH-1:0] r_rdata;
   logic              r_mis;

   logic              w_mis;
   logic              w_load_cnt;
   logic              w_dec;
   logic              w_zero;
   logic              w_access;

`ifdef DMEM_ALIGN_CHK_EN
   assign w_mis = req_addr[0];
`else
   assign w_mis = 1'b0;
`endif

   // Wait counter: loaded on accept, counts down through BUSY.
   dmem_ctrl_wait_counter u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load_cnt),
      .i_load_val (LP_CNT_INIT),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      w_load_cnt  = 1'b0;
      w_dec       = 1'b0;
      w_access    = 1'b0;
      stall       = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               stall       = 1'b1;
               w_load_cnt  = 1'b1;
               w_state_nxt = w_mis ? RESP : BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (w_zero) begin
               w_access    = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_dec = 1'b1;
            end
         end
         RESP: begin
            // Any req_valid seen here belongs to the request just serviced.
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Request capture and load-data latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_mis   <= 1'b0;
      end else begin
         if (w_load_cnt) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mis   <= w_mis;
         end
         if (w_access && !r_wr) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   // Gating with rst guarantees an abort in the final BUSY cycle leaves
   // memory untouched.
   assign mem_en      = w_access & ~rst;
   assign mem_wr      = w_access & r_wr & ~rst;
   assign mem_wdata   = r_wdata;
   assign rdata       = r_rdata;
   assign rdata_valid = (r_state == RESP) & ~r_wr & ~r_mis;

`ifdef DMEM_ALIGN_CHK_EN
   assign mem_addr = r_addr;
   assign err      = (r_state == RESP) & r_mis;
`else
   assign mem_addr = r_addr & ~{{(AWIDTH-1){1'b0}}, 1'b1};
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // LATENCY=4 instance
   logic        req_valid = 1'b0;
   logic        req_wr    = 1'b0;
   logic [15:0] req_addr  = '0;
   logic [15:0] req_wdata = '0;
   logic        stall, rdata_valid, err, mem_en, mem_wr;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

   // LATENCY=1 instance
   logic        q1_valid = 1'b0;
   logic        q1_wr    = 1'b0;
   logic [15:0] q1_addr  = '0;
   logic [15:0] q1_wdata = '0;
   logic        s1_stall, s1_rdv, s1_err, s1_en, s1_wr;
   logic [15:0] s1_rdata, s1_addr, s1_wdata, s1_mrdata;

   logic [15:0] mem   [0:255];
   logic [15:0] mem1  [0:255];
   logic [15:0] model [0:255];

   logic        pre_we   = 1'b0;
   logic [7:0]  pre_idx  = '0;
   logic [15:0] pre_data = '0;

   int          checks   = 0;
   int          failures = 0;
   int          wr_count = 0;
   int          exp_wr   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] mon_exp;

   dmem_ctrl #(.DWIDTH(16), .AWIDTH(16), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   dmem_ctrl #(.DWIDTH(16), .AWIDTH(16), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(q1_valid), .req_wr(q1_wr), .req_addr(q1_addr), .req_wdata(q1_wdata),
      .stall(s1_stall), .rdata(s1_rdata), .rdata_valid(s1_rdv), .err(s1_err),
      .mem_en(s1_en), .mem_wr(s1_wr), .mem_addr(s1_addr), .mem_wdata(s1_wdata),
      .mem_rdata(s1_mrdata)
   );

   // Single-cycle memories: combinational read, write at the clock edge
   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (mem_en && mem_wr) begin
         mem[mem_addr[8:1]] <= mem_wdata;
         wr_count++;
      end
   end
   assign mem_rdata = mem[mem_addr[8:1]];

   always @(posedge clk) begin
      if (s1_en && s1_wr) mem1[s1_addr[8:1]] <= s1_wdata;
   end
   assign s1_mrdata = mem1[s1_addr[8:1]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every load response of the LATENCY=4 instance pops one entry
   always @(negedge clk) begin
      if (rdata_valid) begin
         if (exp_q.size() == 0) check("rdv_spurious", 32'(rdata_valid), 32'd0);
         else begin
            mon_exp = exp_q.pop_front();
            check("sb_rdata", 32'(rdata), 32'(mon_exp));
         end
      end
   end

   // Drives one access on the LATENCY=4 instance starting in an IDLE cycle.
   // hold=1 keeps req_valid high into the following IDLE cycle.
   task automatic access4(input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic hold);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
      if (wr) begin
         model[addr[8:1]] = wd;
         exp_wr++;
      end else begin
         exp_q.push_back(model[addr[8:1]]);
      end
      #1 check("c0_stall", 32'(stall), 32'd1);
      check("c0_en", 32'(mem_en), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); #1;
         check("busy_stall", 32'(stall), 32'd1);
         check("busy_en", 32'(mem_en), 32'(k == 4));
         check("busy_wr", 32'(mem_wr), 32'(wr && (k == 4)));
      end
      @(negedge clk); #1;
      check("resp_stall", 32'(stall), 32'd0);
      check("resp_en", 32'(mem_en), 32'd0);
      check("resp_rdv", 32'(rdata_valid), 32'(!wr));
      if (!hold) req_valid = 1'b0;
      @(negedge clk); #1;
      if (hold) begin
         check("gap_stall", 32'(stall), 32'd1);
         check("gap_en", 32'(mem_en), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_stall"}, 32'(stall), 32'd0);
      check({pfx, "_rdata"}, 32'(rdata), 32'd0);
      check({pfx, "_rdv"}, 32'(rdata_valid), 32'd0);
      check({pfx, "_err"}, 32'(err), 32'd0);
      check({pfx, "_en"}, 32'(mem_en), 32'd0);
      check({pfx, "_wr"}, 32'(mem_wr), 32'd0);
      check({pfx, "_addr"}, 32'(mem_addr), 32'd0);
      check({pfx, "_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   initial begin
      // Preload memory while in reset
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 8'h08; pre_data = 16'hBEEF; model[8'h08] = 16'hBEEF;
      @(negedge clk);
      pre_idx = 8'h20; pre_data = 16'hAAAA; model[8'h20] = 16'hAAAA;
      @(negedge clk);
      pre_we = 1'b0;
      @(negedge clk); #1;
      check_reset_outputs("rst");
      check("rst_s1_stall", 32'(s1_stall), 32'd0);
      rst = 1'b0;
      @(negedge clk); #1;

      // Load of a preloaded word
      access4(1'b0, 16'h0010, 16'h0000, 1'b0);

      // Store then load back
      access4(1'b1, 16'h0020, 16'h1234, 1'b0);
      check("st_mem", 32'(mem[8'h10]), 32'h1234);
      access4(1'b0, 16'h0020, 16'h0000, 1'b0);

      // Back-to-back load, store, load with req_valid held
      access4(1'b0, 16'h0010, 16'h0000, 1'b1);
      access4(1'b1, 16'h0022, 16'h5678, 1'b1);
      access4(1'b0, 16'h0022, 16'h0000, 1'b0);
      check("b2b_wrcnt", 32'(wr_count), 32'(exp_wr));

      // Reset in the final BUSY cycle of a store
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0040; req_wdata = 16'h9999;
      for (int k = 1; k <= 4; k++) @(negedge clk);
      #1 rst = 1'b1; req_valid = 1'b0;
      @(negedge clk); #1;
      check_reset_outputs("abort");
      check("abort_mem", 32'(mem[8'h20]), 32'(model[8'h20]));
      check("abort_wrcnt", 32'(wr_count), 32'(exp_wr));
      rst = 1'b0;
      @(negedge clk); #1;

      // Misaligned request
`ifdef DMEM_ALIGN_CHK_EN
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0011;
      #1 check("mis_c0_stall", 32'(stall), 32'd1);
      check("mis_c0_en", 32'(mem_en), 32'd0);
      @(negedge clk); #1;
      check("mis_err", 32'(err), 32'd1);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_rdv", 32'(rdata_valid), 32'd0);
      check("mis_en", 32'(mem_en), 32'd0);
      req_valid = 1'b0;
      @(negedge clk); #1;
      check("mis_err_clr", 32'(err), 32'd0);
`else
      access4(1'b0, 16'h0011, 16'h0000, 1'b0);
      check("mis_addr", 32'(mem_addr), 32'h0010);
      check("mis_err", 32'(err), 32'd0);
`endif

      // LATENCY=1: store then load
      q1_valid = 1'b1; q1_wr = 1'b1; q1_addr = 16'h0030; q1_wdata = 16'h5A5A;
      #1 check("l1_st_c0_stall", 32'(s1_stall), 32'd1);
      @(negedge clk); #1;
      check("l1_st_c1_stall", 32'(s1_stall), 32'd1);
      check("l1_st_c1_en", 32'(s1_en), 32'd1);
      check("l1_st_c1_wr", 32'(s1_wr), 32'd1);
      @(negedge clk); #1;
      check("l1_st_c2_stall", 32'(s1_stall), 32'd0);
      check("l1_st_c2_rdv", 32'(s1_rdv), 32'd0);
      q1_valid = 1'b0;
      @(negedge clk); #1;
      q1_valid = 1'b1; q1_wr = 1'b0; q1_addr = 16'h0030; q1_wdata = 16'h0000;
      #1 check("l1_ld_c0_stall", 32'(s1_stall), 32'd1);
      @(negedge clk); #1;
      check("l1_ld_c1_en", 32'(s1_en), 32'd1);
      check("l1_ld_c1_wr", 32'(s1_wr), 32'd0);
      @(negedge clk); #1;
      check("l1_ld_c2_stall", 32'(s1_stall), 32'd0);
      check("l1_ld_c2_rdv", 32'(s1_rdv), 32'd1);
      check("l1_ld_rdata", 32'(s1_rdata), 32'h5A5A);
      q1_valid = 1'b0;
      @(negedge clk); #1;
      check("l1_rdv_clr", 32'(s1_rdv), 32'd0);

      // All expected responses consumed, no extra writes
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("final_wrcnt", 32'(wr_count), 32'(exp_wr));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
